// File: rtl/bpu_if.sv
`default_nettype none
// ============================================================================
// Module   : bpu_if
// Brief    : Fetch-side lookup and execute-side resolution bundle of the BPU.
// Revision : 1.0 - initial release
// ============================================================================
interface bpu_if;
    logic [31:0] pc_i;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;
    logic        bp_flush_i;
    logic [31:0] mispredict_cnt_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispredict_i, bp_flush_i,
        input  next_pc_o, next_taken_o, mispredict_cnt_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_mispredict_i, bp_flush_i,
        output next_pc_o, next_taken_o, mispredict_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/bpu.sv
`default_nettype none
// ============================================================================
// Module   : bpu
// Brief    : Direct-mapped BTB with 2-bit direction counters and a
//            saturating mispredict counter; lookup is zero-latency.
// Revision : 1.0 - initial release
// ============================================================================
module bpu #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  wire logic clk_i,
    input  wire logic n_rst_i,
    bpu_if.slave      bp
);
    localparam int c_TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_mispredict_cnt;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic [31:0]        w_seq_pc;

    logic [IDX_W-1:0]   w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_up_write;
    logic               w_up_hit;
    logic               w_up_alloc;
    logic               w_unused;

    // Lookup path: pure function of pc_i and the current table contents.
    assign w_lk_idx   = bp.pc_i[IDX_W+1:2];
    assign w_lk_tag   = bp.pc_i[31:IDX_W+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_seq_pc   = {bp.pc_i[31:2], 2'b00} + 32'd4;

    assign bp.next_taken_o     = w_lk_taken;
    assign bp.next_pc_o        = w_lk_taken ? r_target[w_lk_idx] : w_seq_pc;
    assign bp.mispredict_cnt_o = r_mispredict_cnt;

    // A flush suppresses any table write in the same cycle.
    assign w_up_idx   = bp.upd_pc_i[IDX_W+1:2];
    assign w_up_tag   = bp.upd_pc_i[31:IDX_W+2];
    assign w_up_write = bp.upd_valid_i && !bp.bp_flush_i;
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_alloc = w_up_write && !w_up_hit && bp.upd_taken_i;

    assign w_unused = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_valid <= '0;
        end else if (bp.bp_flush_i) begin
            r_valid <= '0;
        end else if (w_up_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (w_up_write) begin
            if (w_up_hit) begin
                if (bp.upd_taken_i) begin
                    if (r_ctr[w_up_idx] != 2'b11) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    end
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (bp.upd_taken_i) begin
                r_ctr[w_up_idx] <= 2'b10;
            end
        end
    end

    // Tag and target need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (w_up_write && bp.upd_taken_i) begin
            r_target[w_up_idx] <= bp.upd_target_i;
            if (!w_up_hit) begin
                r_tag[w_up_idx] <= w_up_tag;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_mispredict_cnt <= '0;
        end else if (bp.upd_valid_i && bp.upd_mispredict_i &&
                     (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu
// Brief    : Scoreboard bench for bpu: reference BTB model plus directed
//            constant expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpu;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    typedef struct {
        string       tag;
        logic [31:0] npc;
        logic        tk;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic        m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [1:0]  m_ctr   [ENTRIES];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    bpu_if bif ();

    bpu #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bp      (bif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 2'b01;
        end
        m_cnt = '0;
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic [31:0] npc,
                                       output logic tk);
        int i;
        i   = int'(pc[IDX_W+1:2]);
        tk  = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2))) && m_ctr[i][1];
        npc = tk ? m_tgt[i] : ((pc & 32'hFFFF_FFFC) + 32'd4);
    endfunction

    function automatic void model_upd(input logic uv, input logic [31:0] upc, input logic ut,
                                      input logic [31:0] utgt, input logic um, input logic fl);
        int   i;
        logic hit;
        if (uv && um && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (uv) begin
            i   = int'(upc[IDX_W+1:2]);
            hit = m_valid[i] && (m_tag[i] == (upc >> (IDX_W + 2)));
            if (hit) begin
                if (ut) begin
                    if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
                    m_tgt[i] = utgt;
                end else if (m_ctr[i] != 2'b00) begin
                    m_ctr[i] = m_ctr[i] - 2'd1;
                end
            end else if (ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upc >> (IDX_W + 2);
                m_tgt[i]   = utgt;
                m_ctr[i]   = 2'b10;
            end
        end
    endfunction

    task automatic sb_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".npc"}, bif.next_pc_o, e.npc);
        check({e.tag, ".tk"}, {31'd0, bif.next_taken_o}, {31'd0, e.tk});
        check({e.tag, ".cnt"}, bif.mispredict_cnt_o, e.cnt);
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic um, input logic fl);
        bif.pc_i             = pc;
        bif.upd_valid_i      = uv;
        bif.upd_pc_i         = upc;
        bif.upd_taken_i      = ut;
        bif.upd_target_i     = utgt;
        bif.upd_mispredict_i = um;
        bif.bp_flush_i       = fl;
    endtask

    // One clock: drive, push the model's pre-update prediction, compare, clock the model.
    task automatic cycle(input string tag, input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic um, input logic fl);
        exp_t e;
        @(negedge clk);
        drive(pc, uv, upc, ut, utgt, um, fl);
        model_pred(pc, e.npc, e.tk);
        e.cnt = m_cnt;
        e.tag = tag;
        sb.push_back(e);
        #2;
        sb_compare();
        @(posedge clk);
        model_upd(uv, upc, ut, utgt, um, fl);
    endtask

    task automatic idle(input string tag, input logic [31:0] pc);
        cycle(tag, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um);
        cycle(tag, pc, 1'b1, upc, ut, utgt, um, 1'b0);
    endtask

    // Hand-derived expectation, independent of the reference model.
    task automatic expect_const(input string tag, input logic [31:0] pc,
                                input logic [31:0] npc, input logic tk, input logic [31:0] cnt);
        exp_t e;
        @(negedge clk);
        drive(pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        e.tag = tag;
        e.npc = npc;
        e.tk  = tk;
        e.cnt = cnt;
        sb.push_back(e);
        #2;
        sb_compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after 200000 time units");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        model_reset();
        drive(32'h8000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #3;
        check("in_reset.npc", bif.next_pc_o, 32'h8000_0004);
        check("in_reset.tk", {31'd0, bif.next_taken_o}, 32'd0);
        check("in_reset.cnt", bif.mispredict_cnt_o, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        expect_const("post_reset", 32'h8000_0000, 32'h8000_0004, 1'b0, 32'd0);
        idle("post_reset_m", 32'h1234_5677);

        upd("alloc", 32'h8000_0000, 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1);
        expect_const("alloc_hit", 32'h8000_0010, 32'h8000_0100, 1'b1, 32'd1);

        upd("nt1", 32'h8000_0010, 32'h8000_0010, 1'b0, 32'd0, 1'b0);
        upd("nt2", 32'h8000_0010, 32'h8000_0010, 1'b0, 32'd0, 1'b0);
        expect_const("ctr0", 32'h8000_0010, 32'h8000_0014, 1'b0, 32'd1);

        for (int k = 0; k < 4; k++) begin
            upd($sformatf("tk%0d", k), 32'h8000_0010, 32'h8000_0010, 1'b1, 32'h8000_0120, 1'b0);
        end
        upd("dec_sat", 32'h8000_0010, 32'h8000_0010, 1'b0, 32'd0, 1'b0);
        expect_const("ctr2_after_sat", 32'h8000_0010, 32'h8000_0120, 1'b1, 32'd1);

        upd("alias", 32'h8000_0010, 32'h8000_0050, 1'b1, 32'h8000_0200, 1'b1);
        expect_const("alias_old", 32'h8000_0010, 32'h8000_0014, 1'b0, 32'd2);
        expect_const("alias_new", 32'h8000_0050, 32'h8000_0200, 1'b1, 32'd2);

        upd("same_cyc", 32'h8000_0010, 32'h8000_0010, 1'b1, 32'h8000_0300, 1'b0);
        expect_const("same_cyc_next", 32'h8000_0010, 32'h8000_0300, 1'b1, 32'd2);

        cycle("flush_upd", 32'h8000_0010, 1'b1, 32'h8000_0090, 1'b1, 32'h8000_0400, 1'b1, 1'b1);
        expect_const("flush_drop", 32'h8000_0090, 32'h8000_0094, 1'b0, 32'd3);
        expect_const("flush_clr", 32'h8000_0010, 32'h8000_0014, 1'b0, 32'd3);

        upd("lowbits", 32'h8000_0021, 32'h8000_0023, 1'b1, 32'h8000_0400, 1'b0);
        expect_const("lowbits_hit", 32'h8000_0021, 32'h8000_0400, 1'b1, 32'd3);
        idle("lowbits_miss", 32'h8000_0033);
        cycle("mis_no_valid", 32'h8000_0021, 1'b0, 32'h8000_0021, 1'b1, 32'h8000_0500, 1'b1, 1'b0);
        upd("nt_miss", 32'h8000_00A0, 32'h8000_00A0, 1'b0, 32'h8000_0600, 1'b0);
        expect_const("nt_miss_chk", 32'h8000_00A0, 32'h8000_00A4, 1'b0, 32'd3);

        @(negedge clk);
        force dut.r_mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_mispredict_cnt;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            upd($sformatf("sat%0d", k), 32'h8000_0021, 32'h8000_0700, 1'b0, 32'd0, 1'b1);
        end
        expect_const("cnt_sat", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF);
        idle("wrap_pc", 32'hFFFF_FFFF);

        upd("pre_rst", 32'h8000_0010, 32'h8000_0010, 1'b1, 32'h8000_0800, 1'b0);
        expect_const("pre_rst_hit", 32'h8000_0010, 32'h8000_0800, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(32'h8000_0010, 1'b1, 32'h8000_0030, 1'b1, 32'h8000_0900, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst.npc", bif.next_pc_o, 32'h8000_0014);
        check("async_rst.tk", {31'd0, bif.next_taken_o}, 32'd0);
        check("async_rst.cnt", bif.mispredict_cnt_o, 32'd0);
        model_reset();
        @(negedge clk);
        drive(32'h8000_0010, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        n_rst = 1'b1;
        expect_const("rst_drop", 32'h8000_0030, 32'h8000_0034, 1'b0, 32'd0);
        idle("rst_empty", 32'h8000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
